char_box_overlay: RTL and testbench

Video-side consumer of the 8-character vertical-projection results. It captures the eight horizontal character spans and the shared vertical span once per projection cycle, holding them in a frame-stable shadow bank. It draws a rectangular border of configurable colour and thickness around every valid character on the passing RGB stream. It sits after the projection block, on the display path, and re-times video through a fixed 2-cycle pipeline.

---
 rtl/char_proj_pkg.sv | 40 ++++
 rtl/char_box_hit.sv | 52 +++++
 rtl/char_box_overlay.sv | 190 +++++++++++++++++++
 tb/tb_char_box_overlay.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_proj_pkg.sv
// Shared types for the character-projection display path.
// Slot count, coordinate width, span bundle, FSM states, popcount helper.
package char_proj_pkg;

    localparam int CHAR_SLOTS = 8;
    localparam int COORD_W    = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   wide_t;

    typedef struct packed {
        coord_t l;
        coord_t r;
    } span_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } video_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW
    } state_t;

    function automatic logic [3:0] count_ones(
        input logic [CHAR_SLOTS-1:0] bits
    );
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < CHAR_SLOTS; i++) begin
            n = n + {3'b000, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/char_box_hit.sv
// Per-slot hit test: registered in-box and on-border flags for pixel (h,v).
// Ports: pixelclk, reset_n, h_span, v_span, h, v -> in_box, on_border.
module char_box_hit
    import char_proj_pkg::*;
#(
    parameter int BORDER_W = 2
) (
    input  logic   pixelclk,
    input  logic   reset_n,
    input  span_t  h_span,
    input  span_t  v_span,
    input  coord_t h,
    input  coord_t v,
    output logic   in_box,
    output logic   on_border
);

    localparam wide_t BW = wide_t'(BORDER_W);

    // One extra bit so coordinate + thickness never wraps at 4095.
    wide_t h_e, v_e, hl_e, hr_e, vl_e, vr_e;
    logic  in_box_d, in_box_q;
    logic  on_border_d, on_border_q;

    always_comb begin
        h_e  = {1'b0, h};
        v_e  = {1'b0, v};
        hl_e = {1'b0, h_span.l};
        hr_e = {1'b0, h_span.r};
        vl_e = {1'b0, v_span.l};
        vr_e = {1'b0, v_span.r};
        in_box_d = (h_e >= hl_e) && (h_e <= hr_e)
                && (v_e >= vl_e) && (v_e <= vr_e);
        on_border_d = in_box_d
                && ((h_e < hl_e + BW) || (h_e + BW > hr_e)
                 || (v_e < vl_e + BW) || (v_e + BW > vr_e));
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_q    <= 1'b0;
            on_border_q <= 1'b0;
        end else begin
            in_box_q    <= in_box_d;
            on_border_q <= on_border_d;
        end
    end

    assign in_box    = in_box_q;
    assign on_border = on_border_q;

endmodule

// File: rtl/char_box_overlay.sv
// Draws borders around up to 8 captured character boxes; 2-cycle video path.
// Ports: video in/out, coords i_hl*/i_hr*/i_vl/i_vr, o_box_cnt; o_slot when CHAR_SLOT_OUT_EN.
module char_box_overlay
    import char_proj_pkg::*;
#(
    parameter int          LATCH_FRAME = 3,
    parameter int          BORDER_W    = 2,
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic [23:0] i_rgb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_hcount,
    input  logic [11:0] i_vcount,
    input  logic        i_enable,
    input  logic [2:0]  i_frame_cnt,
    input  logic [11:0] i_hl1, i_hl2, i_hl3, i_hl4,
    input  logic [11:0] i_hl5, i_hl6, i_hl7, i_hl8,
    input  logic [11:0] i_hr1, i_hr2, i_hr3, i_hr4,
    input  logic [11:0] i_hr5, i_hr6, i_hr7, i_hr8,
    input  logic [11:0] i_vl,
    input  logic [11:0] i_vr,
    output logic [23:0] o_rgb,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [3:0]  o_box_cnt
`ifdef CHAR_SLOT_OUT_EN
    ,
    output logic [3:0]  o_slot
`endif
);

    span_t [CHAR_SLOTS-1:0] h_in;
    span_t                  v_in;
    logic  [CHAR_SLOTS-1:0] slot_ok;

    assign h_in = {{i_hl8, i_hr8}, {i_hl7, i_hr7},
                   {i_hl6, i_hr6}, {i_hl5, i_hr5},
                   {i_hl4, i_hr4}, {i_hl3, i_hr3},
                   {i_hl2, i_hr2}, {i_hl1, i_hr1}};
    assign v_in = {i_vl, i_vr};

    always_comb begin
        for (int k = 0; k < CHAR_SLOTS; k++) begin
            slot_ok[k] = (h_in[k].r > h_in[k].l)
                      && (h_in[k].r != '0)
                      && (v_in.r > v_in.l);
        end
    end

    // Capture control and frame-stable shadow bank.
    state_t                 state_d, state_q;
    logic                   vs_dly_d, vs_dly_q;
    span_t [CHAR_SLOTS-1:0] h_bank_d, h_bank_q;
    span_t                  v_bank_d, v_bank_q;
    logic  [CHAR_SLOTS-1:0] valid_d, valid_q;
    logic  [3:0]            box_cnt_d, box_cnt_q;
    logic                   capture;

    assign vs_dly_d = i_vs;
    assign capture  = !i_vs && vs_dly_q
                   && (i_frame_cnt == 3'(LATCH_FRAME));

    always_comb begin
        state_d   = state_q;
        h_bank_d  = h_bank_q;
        v_bank_d  = v_bank_q;
        valid_d   = valid_q;
        box_cnt_d = box_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (capture && i_enable) state_d = LOAD;
            end
            LOAD: begin
                state_d   = SHOW;
                h_bank_d  = h_in;
                v_bank_d  = v_in;
                valid_d   = slot_ok;
                box_cnt_d = count_ones(slot_ok);
            end
            SHOW: begin
                if (capture) state_d = i_enable ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            vs_dly_q  <= 1'b0;
            h_bank_q  <= '0;
            v_bank_q  <= '0;
            valid_q   <= '0;
            box_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            vs_dly_q  <= vs_dly_d;
            h_bank_q  <= h_bank_d;
            v_bank_q  <= v_bank_d;
            valid_q   <= valid_d;
            box_cnt_q <= box_cnt_d;
        end
    end

    // Stage 1: hit flags (inside char_box_hit) plus delayed video.
    logic [CHAR_SLOTS-1:0] in_box, on_border;

    for (genvar k = 0; k < CHAR_SLOTS; k++) begin : g_hit
        char_box_hit #(
            .BORDER_W (BORDER_W)
        ) u_hit (
            .pixelclk  (pixelclk),
            .reset_n   (reset_n),
            .h_span    (h_bank_q[k]),
            .v_span    (v_bank_q),
            .h         (i_hcount),
            .v         (i_vcount),
            .in_box    (in_box[k]),
            .on_border (on_border[k])
        );
    end

    video_t s1_d, s1_q;
    logic   show_d, show_q;

    always_comb begin
        s1_d   = '{rgb: i_rgb, hs: i_hs, vs: i_vs, de: i_de};
        show_d = (state_q == SHOW);
    end

    // Stage 2: colour mux. valid_q only moves at the end of LOAD,
    // and a LOAD-cycle pixel never has show set, so it lines up.
    video_t out_d, out_q;
    logic   border_hit;

    always_comb begin
        border_hit = |(on_border & in_box & valid_q);
        out_d      = s1_q;
        if (!s1_q.de) begin
            out_d.rgb = '0;
        end else if (show_q && border_hit) begin
            out_d.rgb = BOX_COLOR;
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            show_q <= 1'b0;
            out_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            show_q <= show_d;
            out_q  <= out_d;
        end
    end

    assign o_rgb     = out_q.rgb;
    assign o_hs      = out_q.hs;
    assign o_vs      = out_q.vs;
    assign o_de      = out_q.de;
    assign o_box_cnt = box_cnt_q;

`ifdef CHAR_SLOT_OUT_EN
    logic [3:0] slot_d, slot_q;

    // Scan high to low so the lowest matching slot wins.
    always_comb begin
        slot_d = '0;
        if (show_q && s1_q.de) begin
            for (int k = CHAR_SLOTS - 1; k >= 0; k--) begin
                if (in_box[k] && valid_q[k]) slot_d = 4'(k + 1);
            end
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) slot_q <= '0;
        else          slot_q <= slot_d;
    end

    assign o_slot = slot_q;
`endif

endmodule

// File: tb/tb_char_box_overlay.sv
// Randomized bench for char_box_overlay against a per-pixel reference model.
// Build with CHAR_SLOT_OUT_EN to also check o_slot.
module tb_char_box_overlay;

    localparam int          LATCH = 3;
    localparam int          BW    = 2;
    localparam logic [23:0] COLOR = 24'hFF0000;
    localparam int          NF    = 40;
    localparam int          FLEN  = 120;

    logic        pixelclk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [23:0] i_rgb = '0;
    logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
    logic [11:0] i_hcount = '0, i_vcount = '0;
    logic        i_enable = 1'b0;
    logic [2:0]  i_frame_cnt = '0;
    logic [11:0] hl[8], hr[8];
    logic [11:0] i_vl = '0, i_vr = '0;
    logic [23:0] o_rgb;
    logic        o_hs, o_vs, o_de;
    logic [3:0]  o_box_cnt;
`ifdef CHAR_SLOT_OUT_EN
    logic [3:0]  o_slot;
`endif

    char_box_overlay #(
        .LATCH_FRAME (LATCH),
        .BORDER_W    (BW),
        .BOX_COLOR   (COLOR)
    ) dut (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .i_rgb       (i_rgb),
        .i_hs        (i_hs),
        .i_vs        (i_vs),
        .i_de        (i_de),
        .i_hcount    (i_hcount),
        .i_vcount    (i_vcount),
        .i_enable    (i_enable),
        .i_frame_cnt (i_frame_cnt),
        .i_hl1 (hl[0]), .i_hl2 (hl[1]), .i_hl3 (hl[2]), .i_hl4 (hl[3]),
        .i_hl5 (hl[4]), .i_hl6 (hl[5]), .i_hl7 (hl[6]), .i_hl8 (hl[7]),
        .i_hr1 (hr[0]), .i_hr2 (hr[1]), .i_hr3 (hr[2]), .i_hr4 (hr[3]),
        .i_hr5 (hr[4]), .i_hr6 (hr[5]), .i_hr7 (hr[6]), .i_hr8 (hr[7]),
        .i_vl        (i_vl),
        .i_vr        (i_vr),
        .o_rgb       (o_rgb),
        .o_hs        (o_hs),
        .o_vs        (o_vs),
        .o_de        (o_de),
        .o_box_cnt   (o_box_cnt)
`ifdef CHAR_SLOT_OUT_EN
        ,
        .o_slot      (o_slot)
`endif
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        int rgb;
        int hs;
        int vs;
        int de;
        int slot;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: mode 0 = pass-through, 1 = loading, 2 = showing.
    int m_mode = 0;
    int s_hl[8], s_hr[8], s_vl = 0, s_vr = 0;
    int s_ok[8];
    int m_cnt = 0;
    int m_vs_prev = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_cnt = 0;
        m_vs_prev = 0;
        s_vl = 0;
        s_vr = 0;
        for (int k = 0; k < 8; k++) begin
            s_hl[k] = 0;
            s_hr[k] = 0;
            s_ok[k] = 0;
        end
        q.delete();
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   h, v, brd, slot, inb;
        h = int'(i_hcount);
        v = int'(i_vcount);
        brd = 0;
        slot = 0;
        for (int k = 0; k < 8; k++) begin
            inb = (h >= s_hl[k] && h <= s_hr[k] && v >= s_vl && v <= s_vr) ? 1 : 0;
            if (s_ok[k] != 0 && inb != 0) begin
                if (slot == 0) slot = k + 1;
                if (h < s_hl[k] + BW || h + BW > s_hr[k] ||
                    v < s_vl + BW || v + BW > s_vr) brd = 1;
            end
        end
        e.hs = int'(i_hs);
        e.vs = int'(i_vs);
        e.de = int'(i_de);
        if (!i_de) e.rgb = 0;
        else if (m_mode == 2 && brd != 0) e.rgb = int'(COLOR);
        else e.rgb = int'(i_rgb);
        e.slot = (m_mode == 2 && i_de) ? slot : 0;
        return e;
    endfunction

    task automatic advance();
        int cap;
        cap = (!i_vs && m_vs_prev != 0 && int'(i_frame_cnt) == LATCH) ? 1 : 0;
        if (m_mode == 1) begin
            s_vl = int'(i_vl);
            s_vr = int'(i_vr);
            m_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                s_hl[k] = int'(hl[k]);
                s_hr[k] = int'(hr[k]);
                s_ok[k] = (s_hr[k] > s_hl[k] && s_hr[k] != 0 && s_vr > s_vl) ? 1 : 0;
                m_cnt += s_ok[k];
            end
            m_mode = 2;
        end else if (cap != 0) begin
            m_mode = i_enable ? 1 : 0;
        end
        m_vs_prev = int'(i_vs);
    endtask

    task automatic sample_and_check();
        exp_t e;
        @(negedge pixelclk);
        check("box_cnt", 32'(o_box_cnt), 32'(m_cnt));
        if (q.size() == 2) begin
            e = q.pop_front();
            check("rgb", 32'(o_rgb), 32'(e.rgb));
            check("hs", 32'(o_hs), 32'(e.hs));
            check("vs", 32'(o_vs), 32'(e.vs));
            check("de", 32'(o_de), 32'(e.de));
`ifdef CHAR_SLOT_OUT_EN
            check("slot", 32'(o_slot), 32'(e.slot));
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rgb"}, 32'(o_rgb), 32'd0);
        check({tag, "_hs"}, 32'(o_hs), 32'd0);
        check({tag, "_vs"}, 32'(o_vs), 32'd0);
        check({tag, "_de"}, 32'(o_de), 32'd0);
        check({tag, "_cnt"}, 32'(o_box_cnt), 32'd0);
`ifdef CHAR_SLOT_OUT_EN
        check({tag, "_slot"}, 32'(o_slot), 32'd0);
`endif
    endtask

    // kind: 0 random, 1 single box, 2 degenerate rows,
    // 3 overlapping pair, 4 box at the coordinate ceiling.
    task automatic set_coords(input int kind);
        for (int k = 0; k < 8; k++) begin
            hl[k] = 12'($urandom_range(0, 120));
            hr[k] = 12'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) begin
                hl[k] = 12'(4080 + $urandom_range(0, 8));
                hr[k] = 12'(4088 + $urandom_range(0, 7));
            end
        end
        i_vl = 12'($urandom_range(0, 100));
        i_vr = 12'($urandom_range(0, 130));
        if (kind >= 1 && kind <= 4) begin
            for (int k = 0; k < 8; k++) begin
                hl[k] = '0;
                hr[k] = '0;
            end
        end
        case (kind)
            1: begin
                hl[0] = 12'd10; hr[0] = 12'd20;
                i_vl = 12'd100; i_vr = 12'd120;
            end
            2: begin
                for (int k = 0; k < 8; k++) begin
                    hl[k] = 12'(k * 15);
                    hr[k] = 12'(k * 15 + 12);
                end
                i_vl = 12'd50; i_vr = 12'd50;
            end
            3: begin
                hl[1] = 12'd30; hr[1] = 12'd60;
                hl[2] = 12'd50; hr[2] = 12'd80;
                i_vl = 12'd100; i_vr = 12'd120;
            end
            4: begin
                hl[0] = 12'd4080; hr[0] = 12'd4095;
                i_vl = 12'd4085; i_vr = 12'd4095;
            end
            default: ;
        endcase
    endtask

    function automatic logic [11:0] pick_coord();
        if ($urandom_range(0, 3) == 0) return 12'(4078 + $urandom_range(0, 17));
        return 12'($urandom_range(0, 130));
    endfunction

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1 check_zero("mid_reset");
        @(posedge pixelclk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            hl[k] = '0;
            hr[k] = '0;
        end
        model_reset();
        repeat (3) @(negedge pixelclk);
        check_zero("reset");
        @(posedge pixelclk);
        #1 reset_n = 1'b1;

        for (int f = 0; f < NF; f++) begin
            for (int c = 0; c < FLEN; c++) begin
                sample_and_check();
                if (c == 0) begin
                    set_coords(f % 6);
                    i_enable = ($urandom_range(0, 3) != 0);
                    i_frame_cnt = ($urandom_range(0, 2) != 0)
                                ? 3'(LATCH) : 3'($urandom_range(0, 4));
                    if (f == 0) i_frame_cnt = 3'd0;
                    if (f == 1 || f == 2) begin
                        i_frame_cnt = 3'(LATCH);
                        i_enable = 1'b1;
                    end
                    if (f == 20) begin
                        i_frame_cnt = 3'(LATCH);
                        i_enable = 1'b0;
                    end
                end
                if (c == 60) begin
                    set_coords(0);
                    i_enable = $urandom_range(0, 1) != 0;
                    i_frame_cnt = 3'($urandom_range(0, 4));
                end
                i_vs = (c < 3);
                i_hs = (c % 40) < 4;
                i_de = (c >= 6) && ($urandom_range(0, 7) != 0);
                i_rgb = 24'($urandom);
                i_hcount = pick_coord();
                i_vcount = pick_coord();
                q.push_back(predict());
                advance();
                if (f == 27 && c == 80) mid_reset();
            end
        end

        sample_and_check();
        sample_and_check();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
